router_packetizer: RTL and testbench



---
 rtl/router_pkg.sv | 17 +
 rtl/router_flit_hold.sv | 85 ++++++++
 rtl/router_packetizer.sv | 145 ++++++++++++++
 tb/tb_router_packetizer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router input-port packetizer slice.
package router_pkg;

  localparam int BIT_OFM_DEF      = 29;
  localparam int PIX_PER_FLIT_DEF = 4;
  localparam int PKT_PIXELS_DEF   = 192;

  typedef enum logic {
    FILL = 1'b0,
    WAIT = 1'b1
  } pktz_state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/router_flit_hold.sv
// Output hold slot of the packetizer: one complete flit, its last-of-packet
// tag and the write/full handshake towards the router input FIFO.
// Optional macro ROUTER_PKTZ_STALL_CNT_EN adds a saturating stall counter.
module router_flit_hold
  #(
    parameter int FLIT_W = 116
  )
  (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [FLIT_W-1:0] load_data,
    input  logic              load_last,
    input  logic              fifo_full,
    output logic [FLIT_W-1:0] flit_data,
    output logic              flit_write,
    output logic              pkt_done,
    output logic              hold_valid,
`ifdef ROUTER_PKTZ_STALL_CNT_EN
    output logic [31:0]       stall_cycles,
`endif
    output logic              slot_free
  );

  logic [FLIT_W-1:0] hold_data_q, hold_data_d;
  logic              hold_valid_q, hold_valid_d;
  logic              hold_last_q, hold_last_d;

  // Handshake and next-state of the hold slot.
  always_comb begin
    flit_write   = hold_valid_q && !fifo_full;
    slot_free    = !hold_valid_q || flit_write;
    pkt_done     = flit_write && hold_last_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    hold_last_d  = hold_last_q;
    if (load) begin
      hold_data_d  = load_data;
      hold_valid_d = 1'b1;
      hold_last_d  = load_last;
    end else if (flit_write) begin
      hold_valid_d = 1'b0;
    end
  end

  // Hold slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
    end else begin
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      hold_last_q  <= hold_last_d;
    end
  end

  assign flit_data  = hold_data_q;
  assign hold_valid = hold_valid_q;

`ifdef ROUTER_PKTZ_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Count cycles a complete flit is blocked by a full FIFO, saturating.
  always_comb begin
    stall_d = stall_q;
    if (hold_valid_q && fifo_full && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: rtl/router_packetizer.sv
// Packs OFM pixels into flits for a router input FIFO and closes every
// packet of PKT_PIXELS pixels with a zero-padded tail flit.
// Optional macro ROUTER_PKTZ_STALL_CNT_EN adds the stall_cycles output.
module router_packetizer
  import router_pkg::*;
  #(
    parameter int BIT_OFM      = BIT_OFM_DEF,
    parameter int PIX_PER_FLIT = PIX_PER_FLIT_DEF,
    parameter int PKT_PIXELS   = PKT_PIXELS_DEF
  )
  (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            pix_valid,
    input  logic [BIT_OFM-1:0]              pix_data,
    output logic                            pix_ready,
    output logic [PIX_PER_FLIT*BIT_OFM-1:0] flit_data,
    output logic                            flit_write,
    input  logic                            fifo_full,
    output logic                            pkt_done,
`ifdef ROUTER_PKTZ_STALL_CNT_EN
    output logic [31:0]                     stall_cycles,
`endif
    output logic                            busy
  );

  localparam int FLIT_W        = PIX_PER_FLIT * BIT_OFM;
  localparam int LANE_W        = (PIX_PER_FLIT > 1) ? $clog2(PIX_PER_FLIT) : 1;
  localparam int PCNT_W        = (PKT_PIXELS > 1) ? $clog2(PKT_PIXELS) : 1;
  localparam int FLITS_PER_PKT = ceil_div(PKT_PIXELS, PIX_PER_FLIT);
  localparam int TAIL_LANES    = PKT_PIXELS - (FLITS_PER_PKT - 1) * PIX_PER_FLIT;
  localparam bit HAS_PAD       = (TAIL_LANES != PIX_PER_FLIT);

  pktz_state_t       state_q, state_d;
  logic [LANE_W-1:0] lane_cnt_q, lane_cnt_d;
  logic [PCNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [FLIT_W-1:0] asm_q, asm_d;
  logic              pend_last_q, pend_last_d;

  logic              accept, last_pix, close;
  logic [FLIT_W-1:0] merged, closed;
  logic              load, load_last;
  logic [FLIT_W-1:0] load_data;
  logic              hold_valid, slot_free;

  // Lane insertion, flit close detection and FILL/WAIT next-state.
  always_comb begin
    state_d     = state_q;
    lane_cnt_d  = lane_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    asm_d       = asm_q;
    pend_last_d = pend_last_q;
    load        = 1'b0;
    load_last   = 1'b0;
    load_data   = '0;

    accept   = pix_valid && (state_q == FILL);
    last_pix = (pix_cnt_q == PCNT_W'(PKT_PIXELS - 1));
    close    = accept && ((lane_cnt_q == LANE_W'(PIX_PER_FLIT - 1)) || last_pix);

    merged = asm_q;
    merged[int'(lane_cnt_q) * BIT_OFM +: BIT_OFM] = pix_data;
    closed = merged;
    for (int unsigned i = 0; i < PIX_PER_FLIT; i++) begin
      if (HAS_PAD && (i > 32'(lane_cnt_q))) begin
        closed[i * BIT_OFM +: BIT_OFM] = '0;
      end
    end

    case (state_q)
      FILL: begin
        if (accept) begin
          pix_cnt_d = last_pix ? '0 : pix_cnt_q + PCNT_W'(1);
          if (close) begin
            if (slot_free) begin
              load       = 1'b1;
              load_data  = closed;
              load_last  = last_pix;
              asm_d      = '0;
              lane_cnt_d = '0;
            end else begin
              // Closed flit parks in assembly until the hold slot drains.
              asm_d       = closed;
              pend_last_d = last_pix;
              state_d     = WAIT;
            end
          end else begin
            asm_d      = merged;
            lane_cnt_d = lane_cnt_q + LANE_W'(1);
          end
        end
      end
      WAIT: begin
        if (flit_write) begin
          load       = 1'b1;
          load_data  = asm_q;
          load_last  = pend_last_q;
          asm_d      = '0;
          lane_cnt_d = '0;
          state_d    = FILL;
        end
      end
    endcase
  end

  // FSM, counters and assembly register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      lane_cnt_q  <= '0;
      pix_cnt_q   <= '0;
      asm_q       <= '0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_cnt_q  <= lane_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      asm_q       <= asm_d;
      pend_last_q <= pend_last_d;
    end
  end

  router_flit_hold #(
    .FLIT_W (FLIT_W)
  ) u_hold (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .load_data    (load_data),
    .load_last    (load_last),
    .fifo_full    (fifo_full),
    .flit_data    (flit_data),
    .flit_write   (flit_write),
    .pkt_done     (pkt_done),
    .hold_valid   (hold_valid),
`ifdef ROUTER_PKTZ_STALL_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .slot_free    (slot_free)
  );

  assign pix_ready = (state_q == FILL);
  assign busy      = hold_valid || (lane_cnt_q != '0) || (state_q == WAIT);

endmodule

// File: tb/tb_router_packetizer.sv
// Scoreboard bench for router_packetizer (BIT_OFM=29, PIX_PER_FLIT=4, PKT_PIXELS=10).
module tb_router_packetizer;

  localparam int BIT = 29;
  localparam int PPF = 4;
  localparam int PKT = 10;
  localparam int FW  = BIT * PPF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_valid = 1'b0;
  logic [BIT-1:0] pix_data = '0;
  logic          fifo_full = 1'b0;
  logic          pix_ready, flit_write, pkt_done, busy;
  logic [FW-1:0] flit_data;
`ifdef ROUTER_PKTZ_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  router_packetizer #(
    .BIT_OFM      (BIT),
    .PIX_PER_FLIT (PPF),
    .PKT_PIXELS   (PKT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_ready    (pix_ready),
    .flit_data    (flit_data),
    .flit_write   (flit_write),
    .fifo_full    (fifo_full),
    .pkt_done     (pkt_done),
`ifdef ROUTER_PKTZ_STALL_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic          last;
    logic [FW-1:0] data;
  } flit_t;

  flit_t         sb[$];
  int unsigned   wr_cyc[$];
  int            n_writes = 0;
  int            n_done = 0;
  int            full_mode = 0;

  // Reference model state: current flit image and position in packet.
  logic [FW-1:0] m_cur = '0;
  int            m_lane = 0;
  int            m_pix = 0;

  function automatic void chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Pixel k of a packet occupies lane k mod PPF of flit k div PPF; a flit is
  // emitted when full or when the packet ends, with unused lanes zero.
  function automatic void model_accept(input logic [BIT-1:0] d);
    m_cur[m_lane*BIT +: BIT] = d;
    m_lane++;
    m_pix++;
    if (m_lane == PPF || m_pix == PKT) begin
      sb.push_back({(m_pix == PKT), m_cur});
      m_cur  = '0;
      m_lane = 0;
      if (m_pix == PKT) m_pix = 0;
    end
  endfunction

  // FIFO full pattern: 0 clear, 1 held, 2 toggling, 3 random.
  always @(posedge clk) begin
    #2;
    case (full_mode)
      0:       fifo_full = 1'b0;
      1:       fifo_full = 1'b1;
      2:       fifo_full = ~fifo_full;
      default: fifo_full = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every write, feeds accepts to the model.
  always @(negedge clk) begin : mon
    flit_t e;
    if (!rst_n) begin
      sb.delete();
      m_cur  = '0;
      m_lane = 0;
      m_pix  = 0;
    end else begin
      if (flit_write) begin
        n_writes++;
        wr_cyc.push_back(cyc);
        chk("write_while_full", FW'(fifo_full), '0);
        if (sb.size() == 0) begin
          chk("unexpected_write", FW'(1), '0);
        end else begin
          e = sb.pop_front();
          chk("flit_data", flit_data, e.data);
          chk("pkt_done", FW'(pkt_done), FW'(e.last));
        end
        if (pkt_done) n_done++;
      end else begin
        chk("pkt_done_idle", FW'(pkt_done), '0);
      end
      if (pix_valid && pix_ready) model_accept(pix_data);
    end
  end

  // Offer n pixels; call at posedge+1. Returns accept edges and stall count.
  task automatic send(input int unsigned n, input int unsigned base, input bit rnd,
                      input int unsigned gap_max, output int unsigned first_edge,
                      output int unsigned last_edge, output int unsigned stalls);
    bit          got;
    int unsigned tries;
    stalls = 0;
    first_edge = 0;
    last_edge = 0;
    for (int unsigned i = 0; i < n; i++) begin
      if (gap_max != 0) begin
        pix_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk);
          #1;
        end
      end
      pix_valid = 1'b1;
      pix_data  = rnd ? BIT'($urandom) : BIT'(base + i);
      tries = 0;
      do begin
        @(negedge clk);
        got = pix_ready;
        @(posedge clk);
        #1;
        tries++;
      end while (!got && tries < 200);
      if (!got) begin
        chk("accept_timeout", '0, FW'(1));
        pix_valid = 1'b0;
        return;
      end
      if (i == 0) first_edge = cyc;
      last_edge = cyc;
      stalls += tries - 1;
    end
    pix_valid = 1'b0;
  endtask

  // Wait until every expected flit is written and nothing is held.
  task automatic wait_idle();
    int unsigned t = 0;
    while (t < 500 && (busy || sb.size() != 0)) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("drain_timeout", '0, FW'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_pix_ready"}, FW'(pix_ready), FW'(1));
    chk({tag, "_flit_write"}, FW'(flit_write), '0);
    chk({tag, "_pkt_done"}, FW'(pkt_done), '0);
    chk({tag, "_busy"}, FW'(busy), '0);
    chk({tag, "_flit_data"}, flit_data, '0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin : stim
    int unsigned   f, l, st, f9;
    int unsigned   exp_off[6];
    logic [FW-1:0] x;
    exp_off = '{3, 7, 9, 13, 17, 19};

    repeat (3) @(posedge clk);
    check_reset_outputs("rst0");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two packets back to back; write offsets from the first accept edge.
    wr_cyc.delete();
    n_writes = 0;
    n_done = 0;
    send(20, 1, 1'b0, 0, f, l, st);
    wait_idle();
    chk("t1_stalls", FW'(st), '0);
    chk("t1_writes", FW'(n_writes), FW'(6));
    chk("t1_done", FW'(n_done), FW'(2));
    if (wr_cyc.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("t1_write_time", FW'(wr_cyc[i] - f), FW'(exp_off[i]));
    end else begin
      chk("t1_write_count", FW'(wr_cyc.size()), FW'(6));
    end

    // FIFO full from the start: two flits buffered, then backpressure.
    full_mode = 1;
    wr_cyc.delete();
    n_writes = 0;
    send(8, 1, 1'b0, 0, f, l, st);
    x = {BIT'(4), BIT'(3), BIT'(2), BIT'(1)};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_pix_ready", FW'(pix_ready), '0);
      chk("t2_flit_write", FW'(flit_write), '0);
      chk("t2_busy", FW'(busy), FW'(1));
      chk("t2_flit_data", flit_data, x);
    end
    @(posedge clk);
    #1 full_mode = 0;
    send(2, 9, 1'b0, 0, f9, l, st);
    wait_idle();
    if (wr_cyc.size() == 3) begin
      chk("t2_back_to_back", FW'(wr_cyc[1]), FW'(wr_cyc[0] + 1));
      chk("t2_pix9_edge", FW'(f9), FW'(wr_cyc[0] + 2));
    end else begin
      chk("t2_write_count", FW'(wr_cyc.size()), FW'(3));
    end

    // Toggling full across three packets.
    full_mode = 2;
    n_writes = 0;
    n_done = 0;
    send(30, 101, 1'b0, 0, f, l, st);
    full_mode = 0;
    wait_idle();
    chk("t3_writes", FW'(n_writes), FW'(9));
    chk("t3_done", FW'(n_done), FW'(3));

    // Reset in the middle of a packet with data held.
    full_mode = 1;
    send(6, 1, 1'b0, 0, f, l, st);
    rst_n = 1'b0;
    check_reset_outputs("rst1");
    @(posedge clk);
    #1 rst_n = 1'b1;
    full_mode = 0;
    n_writes = 0;
    send(4, 1, 1'b0, 0, f, l, st);
    wait_idle();
    chk("t4_writes", FW'(n_writes), FW'(1));

    // Random data, gaps and full pattern.
    full_mode = 3;
    n_done = 0;
    send(60, 0, 1'b1, 2, f, l, st);
    full_mode = 0;
    wait_idle();
    chk("t5_done", FW'(n_done), FW'(6));
    chk("t5_sb_empty", FW'(sb.size()), '0);

`ifdef ROUTER_PKTZ_STALL_CNT_EN
    // Seven blocked cycles with one flit held.
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    full_mode = 1;
    send(4, 1, 1'b0, 0, f, l, st);
    repeat (7) @(posedge clk);
    #1 full_mode = 0;
    wait_idle();
    chk("stall_cycles", FW'(stall_cycles), FW'(7));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
